// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - controller state encoding
//   - PC source select codes
//   - NOP instruction word loaded by the flush consumers
//   - strobe bundle type plus constructors for each pipeline action
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_MDU_WAIT  = 2'd2,
    ST_EXC_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_EXC = 2'b10;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic       pc_wena;
    logic [1:0] pc_sel;
    logic       if_id_wena;
    logic       if_id_flush;
    logic       id_ex_wena;
    logic       id_ex_flush;
    logic       ex_mem_flush;
  } strobes_t;

  // Frozen pipeline: nothing advances, every stage fed a bubble.
  function automatic strobes_t strb_init();
    strobes_t s;
    s = '{pc_wena: 1'b0, pc_sel: PC_SEL_SEQ, if_id_wena: 1'b0, if_id_flush: 1'b1,
          id_ex_wena: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
    return s;
  endfunction

  // Free-running pipeline.
  function automatic strobes_t strb_run();
    strobes_t s;
    s = '{pc_wena: 1'b1, pc_sel: PC_SEL_SEQ, if_id_wena: 1'b1, if_id_flush: 1'b0,
          id_ex_wena: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
    return s;
  endfunction

  // Exception redirect: fetch the vector and squash everything younger than MEM.
  function automatic strobes_t strb_exc();
    strobes_t s;
    s              = strb_run();
    s.pc_sel       = PC_SEL_EXC;
    s.if_id_flush  = 1'b1;
    s.id_ex_flush  = 1'b1;
    s.ex_mem_flush = 1'b1;
    return s;
  endfunction

  // MDU busy: freeze PC..ID/EX so the mult/div stays in EX, bubble into MEM.
  function automatic strobes_t strb_mdu();
    strobes_t s;
    s              = strb_run();
    s.pc_wena      = 1'b0;
    s.if_id_wena   = 1'b0;
    s.id_ex_wena   = 1'b0;
    s.ex_mem_flush = 1'b1;
    return s;
  endfunction

  // RAW hazard: hold PC and IF/ID, inject a bubble into ID/EX.
  function automatic strobes_t strb_hz();
    strobes_t s;
    s             = strb_run();
    s.pc_wena     = 1'b0;
    s.if_id_wena  = 1'b0;
    s.id_ex_flush = 1'b1;
    return s;
  endfunction

  // Taken branch; the delay-slot instruction in IF survives only when ds is set.
  function automatic strobes_t strb_br(input logic ds);
    strobes_t s;
    s             = strb_run();
    s.pc_sel      = PC_SEL_BR;
    s.if_id_flush = ~ds;
    return s;
  endfunction

  // Cycle after an exception: the instruction in ID was fetched from the
  // squashed path, so bubble it out of ID/EX.
  function automatic strobes_t strb_drain();
    strobes_t s;
    s             = strb_run();
    s.id_ex_flush = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   clk_i  - clock
//   rst_i  - async active-high reset, clears the count
//   clr_i  - synchronous clear (wins over inc_i)
//   inc_i  - count one event this cycle
//   cnt_o  - current count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage MIPS core.
// Turns hazard, branch, MDU-busy and exception requests into per-stage
// write enables, flush strobes and the PC source select. Strobes are
// combinational from the registered state and the current inputs so they
// act at the very next posedge.
//   clk_i, rst_i        - clock, async active-high reset
//   hz_stall_i          - RAW stall request
//   br_taken_i          - branch/jump taken in ID
//   mdu_busy_i          - mult/div in EX not done
//   exc_flush_i         - exception/eret committed in MEM
//   pc_wena_o, pc_sel_o - PC write enable and source (seq/branch/vector)
//   if_id_*, id_ex_*    - pipeline register write enables and flushes
//   ex_mem_flush_o      - EX/MEM bubble insert
//   stall_cnt_o         - cycles with PC held (outside startup)
//   flush_cnt_o         - branch + exception redirects
//   err_o               - sticky MDU watchdog error
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter int DELAY_SLOT     = 1,
  parameter int CNT_W          = 32,
  parameter int MDU_TIMEOUT    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hz_stall_i,
  input  logic             br_taken_i,
  input  logic             mdu_busy_i,
  input  logic             exc_flush_i,
  output logic             pc_wena_o,
  output logic [1:0]       pc_sel_o,
  output logic             if_id_wena_o,
  output logic             if_id_flush_o,
  output logic             id_ex_wena_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int IW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int WW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LOAD = IW'(STARTUP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MDU_TIMEOUT);

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  strobes_t      strb;
  logic          stall_inc, flush_inc, cnt_clr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = '0;
    err_d      = err_q;
    strb       = strb_init();
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (state_q == ST_INIT) begin
      // Held frozen; all requests ignored until the pipeline has settled.
      if (init_cnt_q == '0) state_d = ST_RUN;
      else                  init_cnt_d = init_cnt_q - IW'(1);
    end else if (exc_flush_i) begin
      // Exceptions win from every running state, including over MDU busy.
      strb      = strb_exc();
      flush_inc = 1'b1;
      state_d   = ST_EXC_DRAIN;
    end else if (state_q == ST_EXC_DRAIN) begin
      // Stall/branch/busy requests here come from squashed instructions.
      strb    = strb_drain();
      state_d = ST_RUN;
    end else if (mdu_busy_i) begin
      // Wait count is zero in RUN, so the first busy cycle counts as 1.
      strb       = strb_mdu();
      stall_inc  = 1'b1;
      state_d    = ST_MDU_WAIT;
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WW'(1);
      if (wait_cnt_d == WAIT_MAX) err_d = 1'b1;
    end else begin
      // RUN, or MDU_WAIT with busy just dropped: resolve stall/branch now.
      state_d = ST_RUN;
      if (hz_stall_i) begin
        // Branch operands aren't ready yet, so a taken branch is not trusted.
        strb      = strb_hz();
        stall_inc = 1'b1;
      end else if (br_taken_i) begin
        strb      = strb_br(DELAY_SLOT != 0);
        flush_inc = 1'b1;
      end else begin
        strb = strb_run();
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Counters restart cleanly for every startup sequence.
  assign cnt_clr = (state_q == ST_INIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  assign pc_wena_o      = strb.pc_wena;
  assign pc_sel_o       = strb.pc_sel;
  assign if_id_wena_o   = strb.if_id_wena;
  assign if_id_flush_o  = strb.if_id_flush;
  assign id_ex_wena_o   = strb.id_ex_wena;
  assign id_ex_flush_o  = strb.id_ex_flush;
  assign ex_mem_flush_o = strb.ex_mem_flush;
  assign err_o          = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl. Two instances share the stimulus:
//   dut0 - defaults (delay slot, 32-bit counters)
//   dut1 - no delay slot, 4-bit counters (saturation)
// Each cycle the expected strobes and counter snapshot are pushed to a
// scoreboard when stimulus is driven and popped when outputs are sampled,
// 2 time units after the negedge the inputs change on.
module tb_pipe_stall_ctrl;

  logic clk_i = 1'b0;
  logic rst_i, hz_stall_i, br_taken_i, mdu_busy_i, exc_flush_i;

  logic        pc_wena0, if_id_wena0, if_id_flush0, id_ex_wena0, id_ex_flush0, ex_mem_flush0, err0;
  logic [1:0]  pc_sel0;
  logic [31:0] stall_cnt0, flush_cnt0;
  logic        pc_wena1, if_id_wena1, if_id_flush1, id_ex_wena1, id_ex_flush1, ex_mem_flush1, err1;
  logic [1:0]  pc_sel1;
  logic [3:0]  stall_cnt1, flush_cnt1;

  always #5 clk_i = ~clk_i;

  pipe_stall_ctrl u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .hz_stall_i(hz_stall_i), .br_taken_i(br_taken_i),
    .mdu_busy_i(mdu_busy_i), .exc_flush_i(exc_flush_i),
    .pc_wena_o(pc_wena0), .pc_sel_o(pc_sel0), .if_id_wena_o(if_id_wena0),
    .if_id_flush_o(if_id_flush0), .id_ex_wena_o(id_ex_wena0), .id_ex_flush_o(id_ex_flush0),
    .ex_mem_flush_o(ex_mem_flush0), .stall_cnt_o(stall_cnt0), .flush_cnt_o(flush_cnt0),
    .err_o(err0)
  );

  pipe_stall_ctrl #(.DELAY_SLOT(0), .CNT_W(4)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .hz_stall_i(hz_stall_i), .br_taken_i(br_taken_i),
    .mdu_busy_i(mdu_busy_i), .exc_flush_i(exc_flush_i),
    .pc_wena_o(pc_wena1), .pc_sel_o(pc_sel1), .if_id_wena_o(if_id_wena1),
    .if_id_flush_o(if_id_flush1), .id_ex_wena_o(id_ex_wena1), .id_ex_flush_o(id_ex_flush1),
    .ex_mem_flush_o(ex_mem_flush1), .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1),
    .err_o(err1)
  );

  // {pc_wena, pc_sel[1:0], if_id_wena, if_id_flush, id_ex_wena, id_ex_flush, ex_mem_flush}
  typedef logic [7:0] o_t;
  localparam o_t O_INIT = 8'b0_00_0_1_0_1_1;
  localparam o_t O_RUN  = 8'b1_00_1_0_1_0_0;
  localparam o_t O_HZ   = 8'b0_00_0_0_1_1_0;
  localparam o_t O_MDU  = 8'b0_00_0_0_0_0_1;
  localparam o_t O_EXC  = 8'b1_10_1_1_1_1_1;
  localparam o_t O_BRD  = 8'b1_01_1_0_1_0_0;
  localparam o_t O_BRN  = 8'b1_01_1_1_1_0_0;
  localparam o_t O_DRN  = 8'b1_00_1_0_1_1_0;

  // st = {rst, hz, br, mdu, exc}; inc = {stall, flush}
  typedef struct packed {
    logic [4:0] st;
    o_t         e0, e1;
    logic [1:0] inc;
  } row_t;

  typedef struct packed {
    o_t          o0, o1;
    logic [1:0]  err;
    logic [31:0] s0, f0;
    logic [3:0]  s1, f1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_s0 = '0, m_f0 = '0;
  logic [3:0]  m_s1 = '0, m_f1 = '0;
  logic        m_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t observe();
    exp_t g;
    g.o0  = {pc_wena0, pc_sel0, if_id_wena0, if_id_flush0, id_ex_wena0, id_ex_flush0, ex_mem_flush0};
    g.o1  = {pc_wena1, pc_sel1, if_id_wena1, if_id_flush1, id_ex_wena1, id_ex_flush1, ex_mem_flush1};
    g.err = {err0, err1};
    g.s0  = stall_cnt0; g.f0 = flush_cnt0;
    g.s1  = stall_cnt1; g.f1 = flush_cnt1;
    return g;
  endfunction

  // Push expectation (counters as of the previous edges), drive one cycle,
  // then advance the counter model by what this cycle should count.
  task automatic run_cycle(input row_t r);
    exp_t e;
    e.o0 = r.e0; e.o1 = r.e1; e.err = {m_err, m_err};
    e.s0 = m_s0; e.f0 = m_f0; e.s1 = m_s1; e.f1 = m_f1;
    sb.push_back(e);
    @(negedge clk_i);
    {rst_i, hz_stall_i, br_taken_i, mdu_busy_i, exc_flush_i} = r.st;
    #2;
    if (r.inc[1]) begin
      if (m_s0 != '1) m_s0 = m_s0 + 32'd1;
      if (m_s1 != '1) m_s1 = m_s1 + 4'd1;
    end
    if (r.inc[0]) begin
      if (m_f0 != '1) m_f0 = m_f0 + 32'd1;
      if (m_f1 != '1) m_f1 = m_f1 + 4'd1;
    end
  endtask

  task automatic test_reset();
    row_t rows [6];
    exp_t got, e;
    rows = '{'{5'b10000, O_INIT, O_INIT, 2'b00},
             '{5'b11000, O_INIT, O_INIT, 2'b00},
             '{5'b01000, O_INIT, O_INIT, 2'b00},
             '{5'b01000, O_INIT, O_INIT, 2'b00},
             '{5'b00000, O_RUN,  O_RUN,  2'b00},
             '{5'b00000, O_RUN,  O_RUN,  2'b00}};
    foreach (rows[i]) begin
      run_cycle(rows[i]);
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL reset_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL reset_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  task automatic test_hz_stall();
    row_t rows [4];
    exp_t got, e;
    rows = '{'{5'b01100, O_HZ,  O_HZ,  2'b10},
             '{5'b01100, O_HZ,  O_HZ,  2'b10},
             '{5'b00000, O_RUN, O_RUN, 2'b00},
             '{5'b00000, O_RUN, O_RUN, 2'b00}};
    foreach (rows[i]) begin
      run_cycle(rows[i]);
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL hz_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL hz_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  task automatic test_branch();
    row_t rows [4];
    exp_t got, e;
    rows = '{'{5'b00100, O_BRD, O_BRN, 2'b01},
             '{5'b00000, O_RUN, O_RUN, 2'b00},
             '{5'b00100, O_BRD, O_BRN, 2'b01},
             '{5'b00000, O_RUN, O_RUN, 2'b00}};
    foreach (rows[i]) begin
      run_cycle(rows[i]);
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL branch_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL branch_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  // Busy 5 cycles, exception on the 3rd; stall/branch during drain ignored;
  // busy drop with a RAW stall resolves the stall in the same cycle.
  task automatic test_mdu_exc();
    row_t rows [7];
    exp_t got, e;
    rows = '{'{5'b00010, O_MDU, O_MDU, 2'b10},
             '{5'b00010, O_MDU, O_MDU, 2'b10},
             '{5'b00011, O_EXC, O_EXC, 2'b01},
             '{5'b01110, O_DRN, O_DRN, 2'b00},
             '{5'b00010, O_MDU, O_MDU, 2'b10},
             '{5'b01000, O_HZ,  O_HZ,  2'b10},
             '{5'b00000, O_RUN, O_RUN, 2'b00}};
    foreach (rows[i]) begin
      run_cycle(rows[i]);
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL mdu_exc_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL mdu_exc_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  // 20 stall cycles push the 4-bit counter past all-ones.
  task automatic test_saturate();
    exp_t got, e;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) run_cycle('{5'b01000, O_HZ, O_HZ, 2'b10});
      else        run_cycle('{5'b00000, O_RUN, O_RUN, 2'b00});
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL sat_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL sat_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  // Busy for 70 cycles: the 64th busy cycle trips the watchdog, err is
  // visible from the 65th and stays after busy drops.
  task automatic test_timeout();
    exp_t got, e;
    for (int i = 1; i <= 72; i++) begin
      if (i <= 70) run_cycle('{5'b00010, O_MDU, O_MDU, 2'b10});
      else         run_cycle('{5'b00000, O_RUN, O_RUN, 2'b00});
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL timeout_strobes cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL timeout_counters cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
      if (i == 64) m_err = 1'b1;
    end
  endtask

  // Reset asserted between edges during a stall: INIT values at once,
  // counters and err cleared, then a normal startup.
  task automatic test_async_reset();
    row_t rows [4];
    exp_t got, e;
    run_cycle('{5'b01000, O_HZ, O_HZ, 2'b10});
    got = observe(); e = sb.pop_front();
    checks++;
    if ({got.o0, got.o1} !== {e.o0, e.o1}) begin
      errors++; $display("FAIL arst_pre got %h exp %h", {got.o0, got.o1}, {e.o0, e.o1});
    end
    #1 rst_i = 1'b1;
    #1;
    m_s0 = '0; m_f0 = '0; m_s1 = '0; m_f1 = '0; m_err = 1'b0;
    got = observe();
    checks++;
    if ({got.o0, got.o1, got.err} !== {O_INIT, O_INIT, 2'b00}) begin
      errors++; $display("FAIL arst_strobes got %h exp %h", {got.o0, got.o1, got.err}, {O_INIT, O_INIT, 2'b00});
    end
    checks++;
    if ({got.s0, got.f0, got.s1, got.f1} !== '0) begin
      errors++; $display("FAIL arst_counters got %h exp 0", {got.s0, got.f0, got.s1, got.f1});
    end
    rows = '{'{5'b10000, O_INIT, O_INIT, 2'b00},
             '{5'b00000, O_INIT, O_INIT, 2'b00},
             '{5'b00000, O_INIT, O_INIT, 2'b00},
             '{5'b00000, O_RUN,  O_RUN,  2'b00}};
    foreach (rows[i]) begin
      run_cycle(rows[i]);
      got = observe(); e = sb.pop_front();
      checks++;
      if ({got.o0, got.o1, got.err} !== {e.o0, e.o1, e.err}) begin
        errors++; $display("FAIL arst_restart cyc %0d got %h exp %h", i, {got.o0, got.o1, got.err}, {e.o0, e.o1, e.err});
      end
      checks++;
      if ({got.s0, got.f0, got.s1, got.f1} !== {e.s0, e.f0, e.s1, e.f1}) begin
        errors++; $display("FAIL arst_restart_cnt cyc %0d got %h exp %h", i, {got.s0, got.f0, got.s1, got.f1}, {e.s0, e.f0, e.s1, e.f1});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, checks %0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1; hz_stall_i = 1'b0; br_taken_i = 1'b0; mdu_busy_i = 1'b0; exc_flush_i = 1'b0;
    test_reset();
    test_hz_stall();
    test_branch();
    test_mdu_exc();
    test_saturate();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer end of the hazard stall interface in the 5-stage MIPS pipeline. Takes the hazard unit's stall request, branch redirect, multi-cycle MDU busy and exception flush.
- Converts them into per-stage write-enable and flush strobes plus a PC source select.
- Sits between the hazard/branch/MDU/CP0 logic and the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Also keeps saturating stall/flush performance counters and an MDU watchdog.

Parameters:
- STARTUP_CYCLES, 2: cycles the pipeline is held frozen after rst_i deasserts (>=1).
- DELAY_SLOT, 1: 1 = branch delay slot executes, so there is no IF/ID flush on a taken branch; 0 = IF/ID is flushed.
- CNT_W, 32: width of the performance counters.
- MDU_TIMEOUT, 64: maximum consecutive MDU_WAIT cycles before err_o is raised.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- hz_stall_i  in  1  RAW stall request from the hazard unit. It is updated on negedge, so it is stable at posedge.
- br_taken_i  in  1  branch/jump resolved taken in ID this cycle.
- mdu_busy_i  in  1  mult/div unit in EX is not finished.
- exc_flush_i  in  1  exception/eret committed in MEM.
- pc_wena_o  out  1  PC register write enable.
- pc_sel_o  out  2  PC source: 00 = seq, 01 = branch target, 10 = exception vector.
- if_id_wena_o  out  1  IF/ID write enable.
- if_id_flush_o  out  1  IF/ID clear to nop.
- id_ex_wena_o  out  1  ID/EX write enable.
- id_ex_flush_o  out  1  ID/EX clear to bubble.
- ex_mem_flush_o  out  1  EX/MEM clear to bubble.
- stall_cnt_o  out  CNT_W  cycles in which the PC was held (excluding INIT).
- flush_cnt_o  out  CNT_W  branch plus exception redirect events.
- err_o  out  1  sticky MDU watchdog error.

Behaviour:
- State and counters are registered. All strobe outputs are combinational from state and current-cycle inputs, so they take effect at the same posedge (0-cycle latency).
- Reset (async), and for the whole time rst_i is high:
  - state = INIT, init counter = STARTUP_CYCLES-1.
  - All *_wena_o = 0; if_id_flush_o, id_ex_flush_o and ex_mem_flush_o = 1; pc_sel_o = 00.
  - Counters = 0, err_o = 0.
- INIT:
  - Outputs are the same as in reset. The init counter decrements each cycle.
  - Go to RUN on the cycle the counter reaches 0.
  - All other inputs are ignored.
- RUN, inputs evaluated in strict priority order:
  1. exc_flush_i: pc_sel = 10; all wena = 1; if_id, id_ex and ex_mem flushes = 1; flush_cnt += 1; next state = EXC_DRAIN.
  2. mdu_busy_i: pc, if_id and id_ex wena = 0; ex_mem_flush = 1; stall_cnt += 1; next state = MDU_WAIT.
  3. hz_stall_i: pc and if_id wena = 0; id_ex_flush = 1; stall_cnt += 1. br_taken_i is ignored because the branch operands are not ready.
  4. br_taken_i: pc_sel = 01; all wena = 1; if_id_flush = ~DELAY_SLOT; flush_cnt += 1.
  5. Otherwise: all wena = 1, no flushes, pc_sel = 00.
- MDU_WAIT:
  - Outputs are the same as RUN case 2. A wait counter increments each cycle.
  - exc_flush_i is still accepted (case 1 behaviour, wait counter cleared, go to EXC_DRAIN).
  - When mdu_busy_i is low, return to RUN and evaluate RUN rules 3-5 in the same cycle.
  - If the wait counter reaches MDU_TIMEOUT, set err_o = 1 (sticky until reset). The block stays in MDU_WAIT.
- EXC_DRAIN, one cycle:
  - All wena = 1; id_ex_flush = 1; pc_sel = 00.
  - hz_stall_i and br_taken_i are ignored because they come from squashed instructions.
  - A new exc_flush_i is honoured as in RUN case 1.
  - Next state = RUN.
- Counters saturate at all-ones and never wrap.
- Simultaneous exc_flush_i and mdu_busy_i: exception wins; MDU_WAIT is not entered.
- rst_i asserted mid-stall or mid-drain: immediate return to INIT values, no partial cycle.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (INIT, RUN, MDU_WAIT, EXC_DRAIN);
  - PC_SEL_SEQ / PC_SEL_BR / PC_SEL_EXC constants;
  - NOP instruction constant used by the flush consumers.
- One sub-module, sat_counter (parameterised width, inc, sync clear, async reset), instantiated twice.

Test Plan:
- Reset release with STARTUP_CYCLES = 2 → wena = 0 and flushes = 1 for exactly 2 posedges, then pc_wena = 1. hz_stall_i = 1 during INIT leaves stall_cnt = 0.
- RUN, hz_stall_i high 2 cycles with br_taken_i = 1 → pc and if_id wena = 0, id_ex_flush = 1 both cycles, pc_sel = 00, stall_cnt = 2, flush_cnt = 0.
- br_taken_i pulse, DELAY_SLOT = 1 then 0 → pc_sel = 01, if_id_flush = 0 then 1, flush_cnt = 1 then 2.
- mdu_busy_i high 5 cycles, exc_flush_i on cycle 3 → ex_mem_flush = 1 cycles 1-2. On cycle 3: pc_sel = 10 and all flushes = 1. Cycle 4: EXC_DRAIN with id_ex_flush = 1. Cycle 5: RUN case 2 because busy is still high. stall_cnt = 3, flush_cnt = 1.
- mdu_busy_i held 70 cycles, MDU_TIMEOUT = 64 → err_o rises after cycle 64 and stays 1 after busy drops. rst_i clears it.
- stall_cnt forced near all-ones (CNT_W = 4), 20 stall cycles → holds at 15 with no wrap. Async rst_i mid-stall (between edges) → outputs switch to INIT values immediately.
